// File: rtl/debug_unlock_ctrl.sv
// Challenge-response gate that drives debug_mode of the sensitive-state block.
// Optional `DBG_SESSION_TIMEOUT_EN bounds each unlocked session to SESSION_CYCLES.
module debug_unlock_ctrl #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned SESSION_CYCLES = 65536,
  parameter logic [31:0] LFSR_SEED      = 32'hACE12357,
  localparam int unsigned FW = $clog2(MAX_FAILS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   unlock_key,
  input  logic          auth_start,
  output logic [31:0]   challenge,
  output logic          challenge_valid,
  input  logic          resp_valid,
  input  logic [31:0]   resp_data,
  input  logic [3:0]    dbg_req_mode,
  input  logic          relock,
  output logic [3:0]    debug_mode,
  output logic          unlocked,
  output logic          lockout,
  output logic [FW-1:0] fail_cnt
);

  localparam int unsigned LW =
    (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LO_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  if (MAX_FAILS < 1 || LOCKOUT_CYCLES < 1 ||
      SESSION_CYCLES < 1) begin : g_bad_params
    $error("debug_unlock_ctrl: parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    S_LOCKED,
    S_CHAL,
    S_UNLOCKED,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   chal_q, chal_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lo_q, lo_d;
  logic [3:0]    mode_q, mode_d;
  logic          resp_ok;
  logic [FW-1:0] fail_inc;

`ifdef DBG_SESSION_TIMEOUT_EN
  localparam int unsigned SW =
    (SESSION_CYCLES > 1) ? $clog2(SESSION_CYCLES) : 1;
  localparam logic [SW-1:0] SESS_LAST = SW'(SESSION_CYCLES - 1);
  logic [SW-1:0] sess_q, sess_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOCKED;
      lfsr_q  <= LFSR_SEED;
      chal_q  <= '0;
      fail_q  <= '0;
      lo_q    <= '0;
      mode_q  <= '0;
`ifdef DBG_SESSION_TIMEOUT_EN
      sess_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      chal_q  <= chal_d;
      fail_q  <= fail_d;
      lo_q    <= lo_d;
      mode_q  <= mode_d;
`ifdef DBG_SESSION_TIMEOUT_EN
      sess_q  <= sess_d;
`endif
    end
  end

  // Fibonacci taps 32,22,2,1; free-running in every state
  assign lfsr_d = {lfsr_q[30:0],
                   lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign resp_ok  = (resp_data == (chal_q ^ unlock_key));
  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    fail_d  = fail_q;
    lo_d    = lo_q;
    mode_d  = '0;
`ifdef DBG_SESSION_TIMEOUT_EN
    sess_d  = sess_q;
`endif
    unique case (state_q)
      S_LOCKED: begin
        if (!relock && auth_start) begin
          chal_d  = lfsr_q;
          state_d = S_CHAL;
        end
      end
      S_CHAL: begin
        if (relock) begin
          chal_d  = '0;
          state_d = S_LOCKED;
        end else if (resp_valid) begin
          chal_d = '0;
          if (resp_ok) begin
            fail_d  = '0;
            state_d = S_UNLOCKED;
`ifdef DBG_SESSION_TIMEOUT_EN
            sess_d  = '0;
`endif
          end else begin
            fail_d  = fail_inc;
            state_d = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_LOCKED;
          end
        end
      end
      S_UNLOCKED: begin
        if (relock) begin
          state_d = S_LOCKED;
`ifdef DBG_SESSION_TIMEOUT_EN
          sess_d  = '0;
`endif
        end else begin
          mode_d = dbg_req_mode;
`ifdef DBG_SESSION_TIMEOUT_EN
          if (sess_q == SESS_LAST) begin
            state_d = S_LOCKED;
            mode_d  = '0;
            sess_d  = '0;
          end else begin
            sess_d = sess_q + SW'(1);
          end
`endif
        end
      end
      S_LOCKOUT: begin
        // relock deliberately cannot shorten the lockout
        if (lo_q == LO_LAST) begin
          state_d = S_LOCKED;
          fail_d  = '0;
          lo_d    = '0;
        end else begin
          lo_d = lo_q + LW'(1);
        end
      end
      default: state_d = S_LOCKED;
    endcase
  end

  always_comb begin
    debug_mode      = mode_q;
    challenge       = chal_q;
    challenge_valid = (state_q == S_CHAL);
    unlocked        = (state_q == S_UNLOCKED);
    lockout         = (state_q == S_LOCKOUT);
    fail_cnt        = fail_q;
  end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Scoreboard bench for debug_unlock_ctrl: reference model pushes expected
// outputs per cycle, a monitor pops and compares on the falling edge.
module tb_debug_unlock_ctrl;

  localparam int          MF   = 3;
  localparam int          LC   = 1024;
  localparam int          SC   = 16;
  localparam logic [31:0] SEED = 32'hACE12357;
  localparam logic [31:0] KEY  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auth_start = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic [3:0]  dbg_req_mode = '0;
  logic        relock = 1'b0;
  logic [31:0] challenge;
  logic        challenge_valid;
  logic [3:0]  debug_mode;
  logic        unlocked;
  logic        lockout;
  logic [1:0]  fail_cnt;

  always #5 clk = ~clk;

  debug_unlock_ctrl #(
    .MAX_FAILS(MF),
    .LOCKOUT_CYCLES(LC),
    .SESSION_CYCLES(SC),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .unlock_key(KEY),
    .auth_start(auth_start),
    .challenge(challenge),
    .challenge_valid(challenge_valid),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .dbg_req_mode(dbg_req_mode),
    .relock(relock),
    .debug_mode(debug_mode),
    .unlocked(unlocked),
    .lockout(lockout),
    .fail_cnt(fail_cnt)
  );

  typedef struct packed {
    logic [3:0]  dm;
    logic        unl;
    logic        lko;
    logic        cv;
    logic [31:0] ch;
    logic [1:0]  fc;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: abstract session state
  localparam int ML = 0, MC = 1, MU = 2, MO = 3;
  int          m_st;
  logic [31:0] m_lfsr;
  logic [31:0] m_chal;
  int          m_fc, m_lt, m_sc;
  logic [3:0]  m_dm;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  task automatic model_update(input logic r, input logic a,
                              input logic rv, input logic [31:0] rd,
                              input logic [3:0] md, input logic rl);
    logic [31:0] nl;
    logic [3:0]  ndm;
    if (r) begin
      m_st = ML; m_lfsr = SEED; m_chal = '0;
      m_fc = 0; m_lt = 0; m_sc = 0; m_dm = '0;
    end else begin
      nl  = lfsr_next(m_lfsr);
      ndm = '0;
      case (m_st)
        ML: if (!rl && a) begin m_chal = m_lfsr; m_st = MC; end
        MC: begin
          if (rl) begin
            m_chal = '0; m_st = ML;
          end else if (rv) begin
            if (rd == (m_chal ^ KEY)) begin
              m_st = MU; m_fc = 0; m_sc = 0;
            end else begin
              m_fc++;
              m_st = (m_fc == MF) ? MO : ML;
            end
            m_chal = '0;
          end
        end
        MU: begin
          if (rl) m_st = ML;
          else begin
            ndm = md;
`ifdef DBG_SESSION_TIMEOUT_EN
            m_sc++;
            if (m_sc == SC) begin m_st = ML; ndm = '0; end
`endif
          end
        end
        default: begin
          m_lt++;
          if (m_lt == LC) begin m_st = ML; m_fc = 0; m_lt = 0; end
        end
      endcase
      m_lfsr = nl;
      m_dm   = ndm;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.dm  = m_dm;
    o.unl = (m_st == MU);
    o.lko = (m_st == MO);
    o.cv  = (m_st == MC);
    o.ch  = m_chal;
    o.fc  = 2'(m_fc);
    return o;
  endfunction

  task automatic step(input logic r, input logic a, input logic rv,
                      input logic [31:0] rd, input logic [3:0] md,
                      input logic rl);
    @(negedge clk);
    #1;
    rst = r; auth_start = a; resp_valid = rv;
    resp_data = rd; dbg_req_mode = md; relock = rl;
    @(posedge clk);
    model_update(r, a, rv, rd, md, rl);
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic unlock(output logic [31:0] nonce);
    step(0, 0, 0, '0, '0, 1'b1);
    step(0, 1'b1, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 0);
    nonce = m_chal;
    step(0, 0, 1'b1, m_chal ^ KEY, '0, 0);
  endtask

  always @(negedge clk) begin : monitor
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {debug_mode, unlocked, lockout, challenge_valid,
           challenge, fail_cnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle%0d: got dm=%h unl=%b lko=%b cv=%b ch=%h fc=%0d, want dm=%h unl=%b lko=%b cv=%b ch=%h fc=%0d",
                 cyc, a.dm, a.unl, a.lko, a.cv, a.ch, a.fc,
                 e.dm, e.unl, e.lko, e.cv, e.ch, e.fc);
      end
    end
  end

  initial begin
    logic [31:0] pre, nonce, c2;
    int          ucnt;
    obs_t        now;

    repeat (2) step(1'b1, 0, 0, '0, '0, 0);
    repeat (4) step(0, 0, 0, '0, 4'hF, 0);

    unlock(nonce);
    repeat (3) step(0, 0, 0, '0, 4'hF, 0);

    // relock wins over a same-edge response
    step(0, 0, 1'b1, 32'h0, 4'hF, 1'b1);
    step(0, 0, 0, '0, 4'hF, 0);

    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 0, '0, '0, 0);
      step(0, 0, 0, '0, '0, 0);
      step(0, 0, 1'b1, m_chal ^ KEY ^ 32'h1, '0, 0);
    end
    repeat (LC + 4) step(0, 1'b1, 1'b1, $urandom, 4'hF, 0);

    // session length
    unlock(nonce);
    ucnt = int'(unlocked);
    for (int i = 0; i < SC + 4; i++) begin
      step(0, 0, 0, '0, 4'($urandom), 0);
      ucnt += int'(unlocked);
    end
    tests++;
`ifdef DBG_SESSION_TIMEOUT_EN
    if (ucnt != SC) begin
      fails++;
      $display("FAIL session_len: got %0d want %0d", ucnt, SC);
    end
`else
    if (ucnt != SC + 5) begin
      fails++;
      $display("FAIL session_len: got %0d want %0d", ucnt, SC + 5);
    end
`endif

    // async reset in the middle of a session
    unlock(pre);
    repeat (2) step(0, 0, 0, '0, 4'hF, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    now = {debug_mode, unlocked, lockout, challenge_valid,
           challenge, fail_cnt};
    tests++;
    if (now !== '0) begin
      fails++;
      $display("FAIL async_rst: got %h want 0", now);
    end
    repeat (2) step(1'b1, 0, 0, '0, '0, 0);
    step(0, 1'b1, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1'b1);
    step(0, 1'b1, 0, '0, '0, 0);
    c2 = challenge;
    tests++;
    if (c2 == pre) begin
      fails++;
      $display("FAIL nonce_reuse: got %h want != %h", c2, pre);
    end

    for (int i = 0; i < 500; i++) begin
      step(0, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1) ? (m_chal ^ KEY) : $urandom,
           4'($urandom),
           1'($urandom_range(0, 29) == 0));
    end

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
